// File: rtl/nn_instr_issuer.sv
// nn_instr_issuer: issuing end of the nn instruction port.
// The host queues {instr, hold} entries into a FIFO. On start they are driven
// back-to-back onto `instruction`, each for hold+1 cycles, with NOP (0)
// whenever nothing is issuing.
// Optional feature macro: NN_ISSUER_LOOP_EN adds a loop_cnt input. The queued
// program is then replayed loop_cnt extra times and freed after the final pass.
module nn_instr_issuer #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = 24,
    parameter int HOLD_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_valid,
    output logic                     prog_ready,
    input  logic [INSTR_W-1:0]       prog_instr,
    input  logic [HOLD_W-1:0]        prog_hold,
    input  logic                     start,
    input  logic                     abort,
`ifdef NN_ISSUER_LOOP_EN
    input  logic [7:0]               loop_cnt,
`endif
    output logic [INSTR_W-1:0]       instruction,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = INSTR_W + HOLD_W;

    localparam logic [AW-1:0]      PTR_ONE    = AW'(1'b1);
    localparam logic [CW-1:0]      CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0]      CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_FULL   = CW'(DEPTH);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0]  HOLD_ZERO  = {HOLD_W{1'b0}};
    localparam logic [INSTR_W-1:0] INSTR_NOP  = {INSTR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [EW-1:0]      mem_q [DEPTH];
    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic               push_s;
    logic               pop_s;
    logic [AW-1:0]      rd_addr_s;
    logic [EW-1:0]      head_s;
    logic [INSTR_W-1:0] head_instr_s;
    logic [HOLD_W-1:0]  head_hold_s;

`ifdef NN_ISSUER_LOOP_EN
    // Replay state: issue pointer walks the program without freeing it.
    logic [AW-1:0]      iss_ptr_q, iss_ptr_d;
    logic [CW-1:0]      left_q, left_d;
    logic [CW-1:0]      len_q, len_d;
    logic [7:0]         loops_q, loops_d;
    logic               free_s;

    // Entries are locked while a looped program runs.
    assign prog_ready = (count_q != CNT_FULL) && (state_q != ST_ISSUE);
    // Mid-pass reads follow the issue pointer; start and rewind read the oldest entry.
    assign rd_addr_s  = ((state_q == ST_ISSUE) && (left_q != CNT_ZERO)) ? iss_ptr_q : rd_ptr_q;
`else
    assign prog_ready = (count_q != CNT_FULL);
    assign rd_addr_s  = rd_ptr_q;
`endif

    // An abort cycle drops any concurrent push.
    assign push_s       = prog_valid && prog_ready && !abort;
    assign head_s       = mem_q[rd_addr_s];
    assign head_instr_s = head_s[EW-1:HOLD_W];
    assign head_hold_s  = head_s[HOLD_W-1:0];

    assign instruction  = instr_q;
    assign busy         = (state_q == ST_ISSUE);
    assign done         = (state_q == ST_DONE);
    assign fifo_count   = count_q;

    // FIFO storage write port (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {prog_instr, prog_hold};
        end
    end

    // Sequencer next-state, issue register and FIFO pointer/count logic.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        hold_d   = hold_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_s    = 1'b0;
`ifdef NN_ISSUER_LOOP_EN
        iss_ptr_d = iss_ptr_q;
        left_d    = left_q;
        len_d     = len_q;
        loops_d   = loops_q;
        free_s    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                instr_d = INSTR_NOP;
                if (start && (count_q != CNT_ZERO)) begin
                    state_d = ST_ISSUE;
                    instr_d = head_instr_s;
                    hold_d  = head_hold_s;
`ifdef NN_ISSUER_LOOP_EN
                    iss_ptr_d = rd_ptr_q + PTR_ONE;
                    left_d    = count_q - CNT_ONE;
                    len_d     = count_q;
                    loops_d   = loop_cnt;
`else
                    pop_s   = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (hold_q != HOLD_ZERO) begin
                    hold_d = hold_q - HOLD_ONE;
`ifdef NN_ISSUER_LOOP_EN
                end else if (left_q != CNT_ZERO) begin
                    instr_d   = head_instr_s;
                    hold_d    = head_hold_s;
                    iss_ptr_d = iss_ptr_q + PTR_ONE;
                    left_d    = left_q - CNT_ONE;
                end else if (loops_q != 8'd0) begin
                    // Rewind to the first entry of the program without a bubble.
                    instr_d   = head_instr_s;
                    hold_d    = head_hold_s;
                    iss_ptr_d = rd_ptr_q + PTR_ONE;
                    left_d    = len_q - CNT_ONE;
                    loops_d   = loops_q - 8'd1;
                end else begin
                    state_d = ST_DONE;
                    instr_d = INSTR_NOP;
                    free_s  = 1'b1;
                end
`else
                end else if (count_q != CNT_ZERO) begin
                    instr_d = head_instr_s;
                    hold_d  = head_hold_s;
                    pop_s   = 1'b1;
                end else begin
                    // Empty FIFO at end of hold is the end of the program.
                    state_d = ST_DONE;
                    instr_d = INSTR_NOP;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                instr_d = INSTR_NOP;
            end
            default: begin
                state_d = ST_IDLE;
                instr_d = INSTR_NOP;
            end
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

`ifdef NN_ISSUER_LOOP_EN
        // Release the whole program once the final pass has ended.
        if (free_s) begin
            rd_ptr_d = rd_ptr_q + len_q[AW-1:0];
            count_d  = count_q - len_q;
        end else begin
            count_d  = count_d;
        end
`endif

        // Abort flushes the FIFO and returns to idle without a done pulse.
        if (abort) begin
            state_d  = ST_IDLE;
            instr_d  = INSTR_NOP;
            hold_d   = HOLD_ZERO;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = CNT_ZERO;
`ifdef NN_ISSUER_LOOP_EN
            left_d   = CNT_ZERO;
            loops_d  = 8'd0;
`endif
        end else begin
            state_d  = state_d;
        end
    end

    // State, pointer and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            instr_q  <= INSTR_NOP;
            hold_q   <= HOLD_ZERO;
`ifdef NN_ISSUER_LOOP_EN
            iss_ptr_q <= {AW{1'b0}};
            left_q    <= CNT_ZERO;
            len_q     <= CNT_ZERO;
            loops_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            hold_q   <= hold_d;
`ifdef NN_ISSUER_LOOP_EN
            iss_ptr_q <= iss_ptr_d;
            left_q    <= left_d;
            len_q     <= len_d;
            loops_q   <= loops_d;
`endif
        end
    end

endmodule
